// File: rtl/daq_page_ring.sv
// daq_page_ring: page-ring write/read bookkeeping between the event framer and the event buffer.
// Optional high-water tracking is built when DAQ_PAGE_RING_HWM_EN is defined.
module daq_page_ring #(
    parameter  int DATA_W      = 32,
    parameter  int MEM_AW      = 15,
    parameter  int MIN_PAGE_AW = 9,
    parameter  int DROP_W      = 16,
    localparam int PID_W       = MEM_AW - MIN_PAGE_AW,
    localparam int LEN_W       = MIN_PAGE_AW + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [1:0]        page_size,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rd_avail,
    output logic [PID_W-1:0]  rd_page_id,
    output logic [LEN_W-1:0]  rd_len,
    output logic              rd_trunc,
    input  logic              rd_release,
    input  logic [PID_W-1:0]  len_sel,
    output logic [LEN_W:0]    len_peek,
    output logic [PID_W:0]    occupancy,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_count,
    output logic [PID_W:0]    hwm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DISCARD
    } wr_state_e;

    wr_state_e         state_q, state_d;
    logic [1:0]        mode_q;
    logic [PID_W:0]    wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]  offset_q, offset_d;
    logic              trunc_q, trunc_d;
    logic [DROP_W-1:0] drop_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_waddr_q, waddr_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [LEN_W:0]    len_peek_q;
    logic [LEN_W:0]    len_mem [2**PID_W];

    logic [PID_W:0]    ptr_mask, page_cnt, occ_w;
    logic [PID_W-1:0]  id_mask, wr_id, rd_id;
    logic [LEN_W-1:0]  page_words;
    logic              full_w, empty_w, sof_w, eof_w, rel_ok;
    logic              start_ev, drop_ev, word_we, commit;

    // Mode m shrinks the page count by 2^m and grows the page by 2^m; pointers wrap at 2P.
    assign ptr_mask   = {(PID_W+1){1'b1}} >> mode_q;
    assign id_mask    = {PID_W{1'b1}} >> mode_q;
    assign page_cnt   = {1'b1, {PID_W{1'b0}}} >> mode_q;
    assign page_words = {1'b1, {(LEN_W-1){1'b0}}} >> (2'd2 - mode_q);

    assign occ_w   = (wr_ptr_q - rd_ptr_q) & ptr_mask;
    assign full_w  = (occ_w == page_cnt);
    assign empty_w = (occ_w == '0);
    assign wr_id   = wr_ptr_q[PID_W-1:0] & id_mask;
    assign rd_id   = rd_ptr_q[PID_W-1:0] & id_mask;
    assign sof_w   = in_valid & in_sof;
    assign eof_w   = in_valid & in_eof;
    assign rel_ok  = rd_release & ~empty_w & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DISCARD: begin
                if (sof_w)
                    state_d = in_eof ? S_IDLE : (full_w ? S_DISCARD : S_FILL);
                else if (state_q == S_DISCARD && eof_w)
                    state_d = S_IDLE;
            end
            S_FILL:  if (eof_w) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        start_ev = 1'b0;
        drop_ev  = 1'b0;
        word_we  = 1'b0;
        offset_d = offset_q;
        trunc_d  = trunc_q;
        case (state_q)
            S_IDLE, S_DISCARD: begin
                if (sof_w) begin
                    if (full_w) drop_ev  = 1'b1;
                    else        start_ev = 1'b1;
                end
            end
            S_FILL: begin
                if (sof_w) begin
                    // Abort: the partial event is dropped and the new one reuses the same page.
                    start_ev = 1'b1;
                    drop_ev  = 1'b1;
                end else if (in_valid) begin
                    if (offset_q < page_words) begin
                        word_we  = 1'b1;
                        offset_d = offset_q + LEN_W'(1);
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (start_ev) begin
            word_we  = 1'b1;
            offset_d = LEN_W'(1);
            trunc_d  = 1'b0;
        end
        commit  = eof_w & (start_ev | (state_q == S_FILL));
        waddr_d = (MEM_AW'(wr_id) << (MIN_PAGE_AW + 32'(mode_q)))
                | (start_ev ? '0 : MEM_AW'(offset_q));
        if (flush) begin
            word_we = 1'b0;
            commit  = 1'b0;
            drop_ev = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            offset_q    <= '0;
            trunc_q     <= 1'b0;
            drop_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            len_peek_q  <= '0;
        end else begin
            mem_we_q   <= word_we;
            len_peek_q <= len_mem[len_sel];
            if (word_we) begin
                mem_waddr_q <= waddr_d;
                mem_wdata_q <= in_data;
            end
            // The mode may only change while nothing is buffered or being written.
            if (state_q == S_IDLE && empty_w && !sof_w)
                mode_q <= (page_size == 2'd3) ? 2'd2 : page_size;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                offset_q <= '0;
                trunc_q  <= 1'b0;
                drop_q   <= '0;
            end else begin
                offset_q <= offset_d;
                trunc_q  <= trunc_d;
                if (commit) wr_ptr_q <= (wr_ptr_q + (PID_W+1)'(1)) & ptr_mask;
                if (rel_ok) rd_ptr_q <= (rd_ptr_q + (PID_W+1)'(1)) & ptr_mask;
                if (drop_ev && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // NOTE: the length store has no reset; flush keeps it and rd_len is masked until a page commits.
    always_ff @(posedge clk) begin
        if (commit) len_mem[wr_id] <= {trunc_d, offset_d};
    end

`ifdef DAQ_PAGE_RING_HWM_EN
    logic [PID_W:0] hwm_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            hwm_q <= '0;
        else if (flush)          hwm_q <= '0;
        else if (occ_w > hwm_q)  hwm_q <= occ_w;
    end
    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_avail   = ~empty_w;
    assign rd_page_id = rd_id;
    assign rd_len     = rd_avail ? len_mem[rd_id][LEN_W-1:0] : '0;
    assign rd_trunc   = rd_avail ? len_mem[rd_id][LEN_W] : 1'b0;
    assign len_peek   = len_peek_q;
    assign occupancy  = occ_w;
    assign full       = full_w;
    assign empty      = empty_w;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_daq_page_ring.sv
// tb_daq_page_ring: directed scenarios for daq_page_ring with hand-computed expectations.
module tb_daq_page_ring;

    localparam int DATA_W = 32;
    localparam int MEM_AW = 15;
    localparam int PID_W  = 6;
    localparam int LEN_W  = 12;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        page_size = 2'd0;
    logic              in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              rd_release = 1'b0;
    logic [PID_W-1:0]  len_sel = '0;
    logic              mem_we, rd_avail, rd_trunc, full, empty;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [PID_W-1:0]  rd_page_id;
    logic [LEN_W-1:0]  rd_len;
    logic [LEN_W:0]    len_peek;
    logic [PID_W:0]    occupancy, hwm;
    logic [DROP_W-1:0] drop_count;

    int checks = 0;
    int failures = 0;

    daq_page_ring dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .page_size(page_size),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rd_avail(rd_avail), .rd_page_id(rd_page_id), .rd_len(rd_len), .rd_trunc(rd_trunc),
        .rd_release(rd_release), .len_sel(len_sel), .len_peek(len_peek),
        .occupancy(occupancy), .full(full), .empty(empty),
        .drop_count(drop_count), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic rel);
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e; rd_release = rel;
        step();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; rd_release = 1'b0;
    endtask

    task automatic release_page();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
    endtask

    task automatic do_flush(input logic [1:0] ps);
        page_size = ps;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_waddr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL rst_mem_addr_data got %h/%h exp 0/0", mem_waddr, mem_wdata); end
        checks++; if ({rd_avail, rd_page_id, rd_len, rd_trunc} !== '0) begin failures++; $display("FAIL rst_read_side got %b/%0d/%0d/%b exp all 0", rd_avail, rd_page_id, rd_len, rd_trunc); end
        checks++; if (len_peek !== '0) begin failures++; $display("FAIL rst_len_peek got %h exp 0", len_peek); end
        checks++; if (occupancy !== '0 || full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rst_occ got occ=%0d full=%b empty=%b exp 0/0/1", occupancy, full, empty); end
        checks++; if (drop_count !== '0 || hwm !== '0) begin failures++; $display("FAIL rst_counters got drop=%0d hwm=%0d exp 0/0", drop_count, hwm); end
        reset_n = 1'b1;
        step();
        release_page();
        checks++; if (occupancy !== 7'd0 || rd_avail !== 1'b0) begin failures++; $display("FAIL release_when_empty got occ=%0d avail=%b exp 0/0", occupancy, rd_avail); end
    endtask

    task automatic test_single_event();
        do_flush(2'd0);
        for (int i = 0; i < 10; i++) begin
            drive(32'hA000 + i, i == 0, i == 9, 1'b0);
            checks++;
            if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, MEM_AW'(i), 32'hA000 + i}) begin
                failures++; $display("FAIL single_write%0d got we=%b addr=%h data=%h exp 1/%h/%h", i, mem_we, mem_waddr, mem_wdata, i, 32'hA000 + i);
            end
        end
        checks++; if (rd_avail !== 1'b1 || rd_page_id !== 6'd0) begin failures++; $display("FAIL single_head got avail=%b id=%0d exp 1/0", rd_avail, rd_page_id); end
        checks++; if (rd_len !== 12'd10 || rd_trunc !== 1'b0) begin failures++; $display("FAIL single_len got %0d/%b exp 10/0", rd_len, rd_trunc); end
        checks++; if (occupancy !== 7'd1 || empty !== 1'b0) begin failures++; $display("FAIL single_occ got %0d/%b exp 1/0", occupancy, empty); end
        len_sel = 6'd0;
        step();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_we_idle got %b exp 0", mem_we); end
        checks++; if (len_peek !== 13'h00A) begin failures++; $display("FAIL single_peek got %h exp 00a", len_peek); end
        release_page();
        checks++; if (occupancy !== 7'd0 || rd_avail !== 1'b0) begin failures++; $display("FAIL single_release got occ=%0d avail=%b exp 0/0", occupancy, rd_avail); end
        do_flush(2'd0);
        checks++; if (len_peek !== 13'h00A) begin failures++; $display("FAIL flush_keeps_len got %h exp 00a", len_peek); end
    endtask

    task automatic test_truncation();
        int wr_cnt;
        int bad;
        wr_cnt = 0;
        bad = 0;
        do_flush(2'd1);
        for (int i = 0; i < 1100; i++) begin
            drive(DATA_W'(i), i == 0, i == 1099, 1'b0);
            if (mem_we === 1'b1) begin
                if (mem_waddr !== MEM_AW'(wr_cnt)) bad++;
                wr_cnt++;
            end
        end
        checks++; if (wr_cnt != 1024) begin failures++; $display("FAIL trunc_write_count got %0d exp 1024", wr_cnt); end
        checks++; if (bad != 0) begin failures++; $display("FAIL trunc_addresses got %0d wrong exp 0 wrong", bad); end
        checks++; if (rd_avail !== 1'b1 || rd_len !== 12'd1024 || rd_trunc !== 1'b1) begin failures++; $display("FAIL trunc_head got avail=%b len=%0d trunc=%b exp 1/1024/1", rd_avail, rd_len, rd_trunc); end
        release_page();
    endtask

    task automatic test_full_drop();
        logic [PID_W:0] exp_hwm;
`ifdef DAQ_PAGE_RING_HWM_EN
        exp_hwm = 7'd16;
`else
        exp_hwm = 7'd0;
`endif
        do_flush(2'd2);
        for (int k = 0; k < 16; k++) begin
            drive(DATA_W'(k), 1'b1, 1'b1, 1'b0);
            if (k == 14) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early got %b exp 0", full); end
            end
        end
        checks++; if (mem_waddr !== 15'h7800) begin failures++; $display("FAIL full_last_addr got %h exp 7800", mem_waddr); end
        checks++; if (full !== 1'b1 || occupancy !== 7'd16 || drop_count !== 16'd0) begin failures++; $display("FAIL full_state got full=%b occ=%0d drop=%0d exp 1/16/0", full, occupancy, drop_count); end
        drive(32'd99, 1'b1, 1'b1, 1'b0);
        checks++; if (mem_we !== 1'b0 || drop_count !== 16'd1 || occupancy !== 7'd16) begin failures++; $display("FAIL full_drop got we=%b drop=%0d occ=%0d exp 0/1/16", mem_we, drop_count, occupancy); end
        step();
        checks++; if (hwm !== exp_hwm) begin failures++; $display("FAIL hwm got %0d exp %0d", hwm, exp_hwm); end
        drive(32'd98, 1'b1, 1'b0, 1'b1);
        drive(32'd97, 1'b0, 1'b1, 1'b0);
        checks++; if (mem_we !== 1'b0 || drop_count !== 16'd2 || occupancy !== 7'd15) begin failures++; $display("FAIL full_no_rescue got we=%b drop=%0d occ=%0d exp 0/2/15", mem_we, drop_count, occupancy); end
        repeat (15) release_page();
        checks++; if (empty !== 1'b1 || hwm !== exp_hwm) begin failures++; $display("FAIL full_drained got empty=%b hwm=%0d exp 1/%0d", empty, hwm, exp_hwm); end
    endtask

    task automatic test_wrap_back_to_back();
        do_flush(2'd0);
        checks++; if (drop_count !== 16'd0 || hwm !== 7'd0) begin failures++; $display("FAIL flush_clears got drop=%0d hwm=%0d exp 0/0", drop_count, hwm); end
        for (int k = 0; k < 63; k++) drive(DATA_W'(k), 1'b1, 1'b1, 1'b0);
        checks++; if (occupancy !== 7'd63 || full !== 1'b0) begin failures++; $display("FAIL wrap_fill got occ=%0d full=%b exp 63/0", occupancy, full); end
        drive(32'd63, 1'b1, 1'b1, 1'b1);
        checks++; if (mem_waddr !== 15'h7E00 || occupancy !== 7'd63 || rd_page_id !== 6'd1) begin failures++; $display("FAIL wrap_commit_release got addr=%h occ=%0d id=%0d exp 7e00/63/1", mem_waddr, occupancy, rd_page_id); end
        repeat (62) release_page();
        checks++; if (rd_page_id !== 6'd63 || occupancy !== 7'd1) begin failures++; $display("FAIL wrap_head63 got id=%0d occ=%0d exp 63/1", rd_page_id, occupancy); end
        drive(32'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (mem_waddr !== 15'h0000) begin failures++; $display("FAIL wrap_wr_page0 got %h exp 0000", mem_waddr); end
        drive(32'd2, 1'b0, 1'b0, 1'b0);
        drive(32'd3, 1'b0, 1'b1, 1'b1);
        checks++; if (occupancy !== 7'd1 || rd_page_id !== 6'd0 || rd_len !== 12'd3 || mem_waddr !== 15'h0002) begin failures++; $display("FAIL wrap_rd_page0 got occ=%0d id=%0d len=%0d addr=%h exp 1/0/3/0002", occupancy, rd_page_id, rd_len, mem_waddr); end
        release_page();
    endtask

    task automatic test_abort();
        do_flush(2'd0);
        drive(32'd5, 1'b1, 1'b1, 1'b0);
        release_page();
        for (int i = 0; i < 5; i++) drive(DATA_W'(i), i == 0, 1'b0, 1'b0);
        checks++; if (mem_waddr !== 15'h0204) begin failures++; $display("FAIL abort_pre got %h exp 0204", mem_waddr); end
        drive(32'd50, 1'b1, 1'b0, 1'b0);
        checks++; if (drop_count !== 16'd1 || mem_waddr !== 15'h0200 || rd_avail !== 1'b0) begin failures++; $display("FAIL abort_restart got drop=%0d addr=%h avail=%b exp 1/0200/0", drop_count, mem_waddr, rd_avail); end
        drive(32'd51, 1'b0, 1'b0, 1'b0);
        drive(32'd52, 1'b0, 1'b0, 1'b0);
        drive(32'd53, 1'b0, 1'b1, 1'b0);
        checks++; if (mem_waddr !== 15'h0203 || mem_wdata !== 32'd53) begin failures++; $display("FAIL abort_last_word got %h/%0d exp 0203/53", mem_waddr, mem_wdata); end
        checks++; if (occupancy !== 7'd1 || rd_page_id !== 6'd1 || rd_len !== 12'd4 || rd_trunc !== 1'b0) begin failures++; $display("FAIL abort_head got occ=%0d id=%0d len=%0d trunc=%b exp 1/1/4/0", occupancy, rd_page_id, rd_len, rd_trunc); end
        release_page();
    endtask

    task automatic test_mode_change();
        do_flush(2'd0);
        for (int k = 0; k < 3; k++) drive(DATA_W'(k), 1'b1, 1'b1, 1'b0);
        page_size = 2'd2;
        repeat (2) step();
        drive(32'd7, 1'b1, 1'b1, 1'b0);
        checks++; if (mem_waddr !== 15'h0600 || occupancy !== 7'd4) begin failures++; $display("FAIL mode_held got addr=%h occ=%0d exp 0600/4", mem_waddr, occupancy); end
        repeat (4) release_page();
        step();
        drive(32'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (mem_waddr !== 15'h2000) begin failures++; $display("FAIL mode_switched got %h exp 2000", mem_waddr); end
        drive(32'd9, 1'b0, 1'b1, 1'b0);
        checks++; if (mem_waddr !== 15'h2001 || occupancy !== 7'd1 || rd_page_id !== 6'd4 || rd_len !== 12'd2) begin failures++; $display("FAIL mode_event got addr=%h occ=%0d id=%0d len=%0d exp 2001/1/4/2", mem_waddr, occupancy, rd_page_id, rd_len); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_truncation();
        test_full_drop();
        test_wrap_back_to_back();
        test_abort();
        test_mode_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
